// File: rtl/cmp_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmp_arbiter: round-robin sharing of one unsigned magnitude comparator.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module cmp_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_equal,
    output logic                   rsp_greater,
    output logic                   rsp_less
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_id;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic              r_equal;
    logic              r_greater;
    logic              r_less;

    logic              w_found;
    logic [ID_W-1:0]   w_gnt_idx;
    logic [ID_W-1:0]   w_rr_next;
    logic              w_grant;
    logic [N_REQ-1:0]  w_req_ready;

    // Scan from the round-robin pointer upward, wrapping past N_REQ-1.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = int'(r_rr_ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!w_found && req_valid[j]) begin
                w_found   = 1'b1;
                w_gnt_idx = ID_W'(j);
            end
        end
    end

    assign w_grant   = (r_state == ST_IDLE) && w_found && rst_n;
    assign w_rr_next = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        w_req_ready = '0;
        if (w_grant) begin
            w_req_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_equal     <= 1'b0;
            r_greater   <= 1'b0;
            r_less      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_a      <= req_a[w_gnt_idx*WIDTH +: WIDTH];
                        r_b      <= req_b[w_gnt_idx*WIDTH +: WIDTH];
                        r_id     <= w_gnt_idx;
                        r_rr_ptr <= w_rr_next;
                        r_state  <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    r_equal     <= (r_a == r_b);
                    r_greater   <= (r_a > r_b);
                    r_less      <= (r_a < r_b);
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = w_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_equal   = r_equal;
    assign rsp_greater = r_greater;
    assign rsp_less    = r_less;

endmodule
`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cmp_arbiter: directed vectors and sequences for cmp_arbiter.           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_cmp_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = 2;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_equal;
    logic                   rsp_greater;
    logic                   rsp_less;

    int total = 0;
    int bad   = 0;

    cmp_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_equal   (rsp_equal),
        .rsp_greater (rsp_greater),
        .rsp_less    (rsp_less)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // flags are packed {equal, greater, less}
    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] flags;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] flags_now();
        return {rsp_equal, rsp_greater, rsp_less};
    endfunction

    task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
    endtask

    // One complete transaction from a lone requester, entered while IDLE.
    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] flags);
        req_valid = 4'(1 << id);
        set_ops(id, a, b);
        rsp_ready = 1'b1;
        #1;
        chk("op_grant", 32'(req_ready), 32'(1 << id));
        step;
        req_valid = '0;
        #1;
        chk("op_eval_valid", 32'(rsp_valid), 32'd0);
        chk("op_eval_ready", 32'(req_ready), 32'd0);
        step;
        #1;
        chk("op_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("op_rsp_id", 32'(rsp_id), 32'(id));
        chk("op_rsp_flags", 32'(flags_now()), 32'(flags));
        step;
        #1;
        chk("op_rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    logic [2:0] held_flags;

    initial begin
        vecs[0] = '{0, 8'h35, 8'h35, 3'b100};
        vecs[1] = '{0, 8'h00, 8'hFF, 3'b001};
        vecs[2] = '{1, 8'hFF, 8'h00, 3'b010};
        vecs[3] = '{2, 8'hFF, 8'hFF, 3'b100};
        vecs[4] = '{3, 8'h80, 8'h7F, 3'b010};
        vecs[5] = '{1, 8'h7F, 8'h80, 3'b001};
        vecs[6] = '{2, 8'h01, 8'h00, 3'b010};
        vecs[7] = '{3, 8'h00, 8'h00, 3'b100};

        rst_n     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_flags", 32'(flags_now()), 32'd0);
        step;
        step;
        rst_n = 1'b1;
        step;

        // Vector table; entries 4->5 also cover wrap (grant 3, then lone 1).
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].flags);
            step;
        end

        // All four requesting continuously: order 0,1,2,3,0, three cycles apart.
        for (int i = 0; i < N_REQ; i++) begin
            set_ops(i, 8'(i), 8'h02);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % N_REQ;
            chk("rr_grant", 32'(req_ready), 32'(1 << e));
            step;
            #1;
            chk("rr_eval_ready", 32'(req_ready), 32'd0);
            step;
            #1;
            chk("rr_rsp_ready", 32'(req_ready), 32'd0);
            chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rr_rsp_id", 32'(rsp_id), 32'(e));
            chk("rr_flags", 32'(flags_now()),
                (e < 2) ? 32'b001 : ((e == 2) ? 32'b100 : 32'b010));
            step;
            #1;
        end
        req_valid = '0;
        step;
        step;
        step;

        // Backpressure: grant 1 (pointer moves to 2), stall the response.
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        set_ops(1, 8'h10, 8'h20);
        set_ops(2, 8'h22, 8'h22);
        #1;
        chk("bp_grant1", 32'(req_ready), 32'b0010);
        step;
        req_valid = 4'b1110;
        step;
        #1;
        held_flags = flags_now();
        chk("bp_first_flags", 32'(held_flags), 32'b001);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid_hold", 32'(rsp_valid), 32'd1);
            chk("bp_id_hold", 32'(rsp_id), 32'd1);
            chk("bp_flags_hold", 32'(flags_now()), 32'(held_flags));
            chk("bp_no_grant", 32'(req_ready), 32'd0);
            step;
            #1;
        end
        rsp_ready = 1'b1;
        step;
        #1;
        chk("bp_released", 32'(rsp_valid), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'b0100);
        step;
        req_valid = '0;
        step;
        #1;
        chk("bp_next_id", 32'(rsp_id), 32'd2);
        chk("bp_next_flags", 32'(flags_now()), 32'b100);
        step;
        step;

        // Reset during EVAL after granting 1 (pointer would be 2).
        req_valid = 4'b0010;
        set_ops(1, 8'h05, 8'h05);
        #1;
        chk("rm_grant", 32'(req_ready), 32'b0010);
        step;
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        chk("rm_valid", 32'(rsp_valid), 32'd0);
        chk("rm_id", 32'(rsp_id), 32'd0);
        chk("rm_flags", 32'(flags_now()), 32'd0);
        chk("rm_ready", 32'(req_ready), 32'd0);
        step;
        step;
        #1;
        chk("rm_no_delivery", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        step;
        req_valid = 4'b0101;
        set_ops(0, 8'h03, 8'h04);
        #1;
        chk("rm_ptr_zero", 32'(req_ready), 32'b0001);
        step;
        req_valid = '0;
        step;
        #1;
        chk("rm_first_id", 32'(rsp_id), 32'd0);
        chk("rm_first_flags", 32'(flags_now()), 32'b001);
        step;
        step;
        do_op(2, 8'h44, 8'h40, 3'b010);
        step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
